// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht: EX-stage branch/jump resolution with redirect select,
// a saturating-counter branch history table and branch/mispredict counters.
module branch_resolve_bht #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic [31:0]       ex_inst,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic              ex_pred_taken,
    input  logic              BrEq,
    input  logic              BrLT,
    output logic [1:0]        pc_sel,
    output logic              flush,
    output logic              ill_branch,
    output logic [PERF_W-1:0] branch_cnt,
    output logic [PERF_W-1:0] mispred_cnt
);
    localparam int IDX = $clog2(BHT_ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;

    logic [CTR_BITS-1:0] bht [BHT_ENTRIES];
    logic [6:0]          op;
    logic [2:0]          f3;
    logic                act, is_br, is_jmp, br_ill, cond, taken;
    logic [IDX-1:0]      ex_idx;
    logic [CTR_BITS-1:0] ctr, ctr_nxt;
    logic                unused_bits;

    assign op     = ex_inst[6:0];
    assign f3     = ex_inst[14:12];
    assign act    = ex_valid & ~ex_stall;
    assign is_br  = op == 7'b1100011;
    assign is_jmp = op == 7'b1101111 || op == 7'b1100111;
    assign br_ill = is_br && f3[2:1] == 2'b01;
    assign cond   = act & is_br & ~br_ill;
    // f3[2] picks the LT family, f3[0] inverts the sense
    assign taken  = f3[2] ? (BrLT ^ f3[0]) : (BrEq ^ f3[0]);

    always_comb begin
        pc_sel = !act ? 2'b00 :
                 is_jmp ? 2'b01 :
                 !cond ? 2'b00 :
                 (taken & ~ex_pred_taken) ? 2'b01 :
                 (~taken & ex_pred_taken) ? 2'b10 : 2'b00;
    end

    assign flush      = |pc_sel;
    assign ill_branch = act & br_ill;

    assign ex_idx        = ex_pc[IDX+1:2];
    assign if_pred_taken = bht[if_pc[IDX+1:2]][CTR_BITS-1];
    assign ctr           = bht[ex_idx];
    assign ctr_nxt       = taken ? ((ctr == CTR_MAX) ? ctr : ctr + 1'b1)
                                 : ((ctr == '0) ? ctr : ctr - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_INIT;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (cond) begin
            bht[ex_idx] <= ctr_nxt;
            branch_cnt  <= branch_cnt + PERF_W'(1);
            mispred_cnt <= mispred_cnt + PERF_W'(flush);
        end
    end

    assign unused_bits = ^{if_pc[XLEN-1:IDX+2], if_pc[1:0], ex_pc[XLEN-1:IDX+2],
                           ex_pc[1:0], ex_inst[31:15], ex_inst[11:7]};
endmodule

// File: tb/tb_branch_resolve_bht.sv
// tb_branch_resolve_bht: directed vectors with hand-computed expectations,
// small table and narrow perf counters so wrap-around is reachable quickly.
module tb_branch_resolve_bht;
    localparam int XLEN = 32, ENT = 16, CB = 2, PW = 3;

    logic            clk = 0, rst_n = 0;
    logic [XLEN-1:0] if_pc = '0, ex_pc = '0;
    logic            if_pred_taken, ex_valid = 0, ex_stall = 0, ex_pred_taken = 0;
    logic            BrEq = 0, BrLT = 0, flush, ill_branch;
    logic [31:0]     ex_inst = '0;
    logic [1:0]      pc_sel;
    logic [PW-1:0]   branch_cnt, mispred_cnt;
    int              vecs = 0, errs = 0;

    localparam logic [31:0] JAL = 32'h0000006f, JALR = 32'h00000067;

    branch_resolve_bht #(.XLEN(XLEN), .BHT_ENTRIES(ENT), .CTR_BITS(CB), .PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_inst(ex_inst), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .BrEq(BrEq), .BrLT(BrLT), .pc_sel(pc_sel),
        .flush(flush), .ill_branch(ill_branch), .branch_cnt(branch_cnt),
        .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] br(input logic [2:0] f3);
        return {17'b0, f3, 5'b0, 7'b1100011};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic st, input logic [31:0] inst,
                         input logic [XLEN-1:0] pc, input logic p, input logic eq, input logic lt);
        ex_valid = v; ex_stall = st; ex_inst = inst; ex_pc = pc;
        ex_pred_taken = p; BrEq = eq; BrLT = lt;
        #1;
    endtask

    task automatic look(input string tag, input logic [XLEN-1:0] pc, input logic exp);
        if_pc = pc;
        #1;
        check(tag, if_pred_taken, exp);
    endtask

    task automatic cnts(input string tag, input logic [PW-1:0] b, input logic [PW-1:0] m);
        check({tag, "_branch_cnt"}, branch_cnt, b);
        check({tag, "_mispred_cnt"}, mispred_cnt, m);
    endtask

    initial begin
        logic [3:0] tk;
        logic       t;
        // resolution follows the EX inputs even while reset is held
        drive(1, 0, JAL, 0, 0, 0, 0);
        check("rst_jal_pc_sel", pc_sel, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick;
        look("rst_pred", 32'h0, 0);
        rst_n = 1;
        tick;

        // 1: reset state and first mispredicted BEQ
        for (int i = 0; i < ENT; i++) look($sformatf("init_pred_%0d", i), i * 4, 0);
        cnts("init", 0, 0);
        drive(1, 0, br(3'b000), 32'h100, 0, 1, 0);
        check("beq1_pc_sel", pc_sel, 2'b01);
        check("beq1_flush", flush, 1);
        tick;
        cnts("beq1", 1, 1);
        look("ctr10_pred", 32'h100, 1);

        // 2: saturate up, then two not-taken steps back down
        drive(1, 0, br(3'b000), 32'h100, 1, 1, 0);
        check("beq2_pc_sel", pc_sel, 2'b00);
        tick;
        drive(1, 0, br(3'b000), 32'h100, 1, 1, 0);
        tick;
        look("ctr11_pred", 32'h100, 1);
        drive(1, 0, br(3'b000), 32'h100, 1, 0, 0);
        check("nt1_pc_sel", pc_sel, 2'b10);
        check("nt1_flush", flush, 1);
        tick;
        look("sat_ctr10_pred", 32'h100, 1);
        drive(1, 0, br(3'b000), 32'h100, 1, 0, 0);
        tick;
        look("ctr01_pred", 32'h100, 0);
        cnts("seq", 5, 3);

        // 3: funct3 x {BrEq,BrLT} x pred; tk bit index is {BrEq,BrLT}
        for (int f = 0; f < 8; f++) begin
            if (f == 2 || f == 3) continue;
            tk = (f == 0) ? 4'b1100 : (f == 1) ? 4'b0011 :
                 (f == 4 || f == 6) ? 4'b1010 : 4'b0101;
            for (int c = 0; c < 4; c++)
                for (int p = 0; p < 2; p++) begin
                    drive(1, 0, br(3'(f)), 32'h14, p[0], c[1], c[0]);
                    t = tk[c];
                    check($sformatf("tbl_f%0d_c%0d_p%0d", f, c, p), pc_sel,
                          (t && p == 0) ? 2'b01 : (!t && p == 1) ? 2'b10 : 2'b00);
                    tick;
                end
        end
        cnts("tbl", 3'd5, 3'd3);
        drive(1, 0, br(3'b000), 32'h0, 0, 1, 0);
        tick;
        cnts("idx0", 3'd6, 3'd4);
        look("idx0_pred", 32'h0, 1);
        drive(1, 0, br(3'b010), 32'h0, 1, 0, 0);
        check("ill010_flag", ill_branch, 1);
        check("ill010_pc_sel", pc_sel, 2'b00);
        check("ill010_flush", flush, 0);
        tick;
        drive(1, 0, br(3'b011), 32'h0, 1, 0, 1);
        check("ill011_flag", ill_branch, 1);
        tick;
        cnts("ill", 3'd6, 3'd4);
        look("ill_no_write", 32'h0, 1);

        // 4: jumps always redirect; stalls and bubbles never act
        for (int j = 0; j < 4; j++) begin
            drive(1, 0, j[1] ? JALR : JAL, 32'h0, j[0], 0, 0);
            check($sformatf("jump%0d_pc_sel", j), pc_sel, 2'b01);
            tick;
        end
        cnts("jump", 3'd6, 3'd4);
        look("jump_no_write", 32'h0, 1);
        drive(1, 1, br(3'b001), 32'h0, 1, 1, 0);
        check("stall_pc_sel", pc_sel, 2'b00);
        check("stall_flush", flush, 0);
        tick;
        drive(0, 0, br(3'b001), 32'h0, 1, 1, 0);
        check("bubble_pc_sel", pc_sel, 2'b00);
        tick;
        drive(1, 1, br(3'b010), 32'h0, 0, 0, 0);
        check("stall_ill", ill_branch, 0);
        tick;
        cnts("stall", 3'd6, 3'd4);
        look("stall_no_write", 32'h0, 1);

        // 5: aliasing lookup sees the old counter, then counter wrap
        drive(1, 0, br(3'b001), 32'h0, 1, 1, 0);
        check("alias_pc_sel", pc_sel, 2'b10);
        look("alias_old", 32'h0 + 4 * ENT, 1);
        tick;
        look("alias_new", 32'h0 + 4 * ENT, 0);
        cnts("alias", 3'd7, 3'd5);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, br(3'b000), 32'h8, 0, 1, 0);
            tick;
            if (k == 1) check("mispred_max", mispred_cnt, 3'd7);
        end
        cnts("wrap", 3'd2, 3'd0);
        look("idx2_pred", 32'h8, 1);

        // 6: reset mid-cycle with an update pending
        drive(1, 0, br(3'b000), 32'h0, 0, 1, 0);
        #2;
        rst_n = 0;
        #1;
        cnts("rst_async", 0, 0);
        check("rst_pending_pc_sel", pc_sel, 2'b01);
        look("rst_idx2_pred", 32'h8, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1;
        tick;
        cnts("post_rst", 0, 0);
        look("post_rst_idx0", 32'h0, 0);
        drive(1, 0, br(3'b000), 32'h8, 0, 1, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        look("post_rst_init01", 32'h8, 1);
        cnts("post_rst_upd", 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
